// File: rtl/dec_pkg.sv
// Shared encodings for the decoder family: mode field values and the
// coarse operating state that the mode field selects.
package dec_pkg;

  localparam logic [1:0] MODE_OFF       = 2'b00;
  localparam logic [1:0] MODE_DIRECT    = 2'b01;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b10;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_OFF:                     return ST_OFF;
      MODE_DIRECT:                  return ST_DIRECT;
      MODE_SCAN_UP, MODE_SCAN_DOWN: return ST_SCAN;
      default:                      return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dec_scan_if.sv
// Control/status bundle between a decoder controller (master) and dec_scan (slave).
interface dec_scan_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic               load;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (
    output en, mode, sel, load, dwell,
    input  y, idx, valid, wrap
  );

  modport slave (
    input  en, mode, sel, load, dwell,
    output y, idx, valid, wrap
  );

endinterface

// File: rtl/dec_onehot.sv
// Purely combinational SEL_W -> 2**SEL_W one-hot decoder, reusable across
// the decoder library.
module dec_onehot #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   y
);

  always_comb begin
    y      = '0;
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered binary-to-one-hot decoder with direct-select and auto-scan
// modes; all outputs come straight from flops so selects never glitch.
module dec_scan #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  dec_scan_if.slave bus
);
  import dec_pkg::*;

  localparam int OUT_W = 2 ** SEL_W;

  state_t             state;
  state_t             next_state;
  logic               scan_down;
  logic               mode_changed;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_next;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_next;
  logic [OUT_W-1:0]   y_q;
  logic [OUT_W-1:0]   y_next;
  logic [OUT_W-1:0]   onehot_next;
  logic               valid_q;
  logic               wrap_q;
  logic               wrap_next;

  dec_onehot #(.SEL_W(SEL_W)) u_onehot (
    .sel (idx_next),
    .y   (onehot_next)
  );

  // A direction flip counts as a mode change so the new direction starts
  // with a fresh dwell; a load always wins over a step due the same cycle.
  always_comb begin
    next_state   = mode_to_state(bus.mode);
    mode_changed = (next_state != state) ||
                   ((next_state == ST_SCAN) && ((bus.mode == MODE_SCAN_DOWN) != scan_down));
    idx_next     = idx_q;
    cnt_next     = '0;
    wrap_next    = 1'b0;
    if (bus.load) begin
      idx_next = bus.sel;
    end else if ((next_state == ST_SCAN) && !mode_changed) begin
      if (cnt >= bus.dwell) begin
        if (bus.mode == MODE_SCAN_DOWN) begin
          idx_next  = idx_q - SEL_W'(1);
          wrap_next = (idx_q == '0);
        end else begin
          idx_next  = idx_q + SEL_W'(1);
          wrap_next = (idx_q == SEL_W'(OUT_W - 1));
        end
      end else begin
        cnt_next = cnt + DWELL_W'(1);
      end
    end
    y_next = (next_state == ST_OFF) ? '0 : onehot_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      scan_down <= 1'b0;
      cnt       <= '0;
      idx_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (!bus.en) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state     <= next_state;
      scan_down <= (bus.mode == MODE_SCAN_DOWN);
      cnt       <= cnt_next;
      idx_q     <= idx_next;
      y_q       <= y_next;
      valid_q   <= (next_state != ST_OFF);
      wrap_q    <= wrap_next;
    end
  end

  assign bus.y     = y_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Self-checking bench for dec_scan: directed scenarios plus randomized
// traffic compared against a cycle-level arithmetic model of the decoder.
module tb_dec_scan;

  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2 ** SEL_W;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int               m_idx;
  int               m_cnt;
  int               m_prev_mode;
  logic [OUT_W-1:0] m_y;
  logic             m_valid;
  logic             m_wrap;

  dec_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  dec_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_idx       = 0;
    m_cnt       = 0;
    m_prev_mode = 0;
    m_y         = '0;
    m_valid     = 1'b0;
    m_wrap      = 1'b0;
  endtask

  // Behavioural view: modes as integers, index stepping as modular arithmetic.
  task automatic model_edge(input logic e, input int mode, input int sel,
                            input logic load, input int dwell);
    int nxt;
    bit changed;
    if (!e) begin
      m_y     = '0;
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      return;
    end
    m_wrap      = 1'b0;
    changed     = (mode != m_prev_mode);
    m_prev_mode = mode;
    if (mode < 2) begin
      if (load) m_idx = sel;
      m_cnt = 0;
    end else if (load) begin
      m_idx = sel;
      m_cnt = 0;
    end else if (changed) begin
      m_cnt = 0;
    end else if (m_cnt >= dwell) begin
      m_cnt = 0;
      if (mode == 2) begin
        nxt    = (m_idx + 1) % OUT_W;
        m_wrap = (nxt < m_idx);
      end else begin
        nxt    = (m_idx + OUT_W - 1) % OUT_W;
        m_wrap = (nxt > m_idx);
      end
      m_idx = nxt;
    end else begin
      m_cnt++;
    end
    m_y     = (mode == 0) ? '0 : (OUT_W'(1) << m_idx);
    m_valid = (m_y != '0);
  endtask

  task automatic applyStimulus(input logic e, input int mode, input int sel,
                               input logic load, input int dwell);
    bus.en    = e;
    bus.mode  = 2'(mode);
    bus.sel   = SEL_W'(sel);
    bus.load  = load;
    bus.dwell = DWELL_W'(dwell);
    @(posedge clk);
    model_edge(e, mode, sel, load, dwell);
    #1;
    checkOutput("y", 32'(bus.y), 32'(m_y));
    checkOutput("idx", 32'(bus.idx), 32'(m_idx));
    checkOutput("valid", 32'(bus.valid), 32'(m_valid));
    checkOutput("wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  initial begin
    int exp_up[6];
    int exp_dn[3];
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 2'b00;
    bus.sel   = '0;
    bus.load  = 1'b0;
    bus.dwell = '0;
    model_reset();

    #12;
    checkOutput("rst_y", 32'(bus.y), 32'h0);
    checkOutput("rst_valid", 32'(bus.valid), 32'h0);
    checkOutput("rst_idx", 32'(bus.idx), 32'h0);
    checkOutput("rst_wrap", 32'(bus.wrap), 32'h0);
    rst_n = 1'b1;

    // Direct load of 5.
    applyStimulus(1'b1, 1, 5, 1'b1, 0);
    checkOutput("direct_y", 32'(bus.y), 32'h0020);
    checkOutput("direct_idx", 32'(bus.idx), 32'd5);
    applyStimulus(1'b1, 1, 9, 1'b0, 0);
    checkOutput("direct_hold", 32'(bus.y), 32'h0020);

    // Scan up, dwell 2, from 14.
    applyStimulus(1'b1, 2, 14, 1'b1, 2);
    checkOutput("up_load", 32'(bus.idx), 32'd14);
    exp_up = '{14, 14, 15, 15, 15, 0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2, 0, 1'b0, 2);
      checkOutput("up_seq", 32'(bus.idx), 32'(exp_up[i]));
      checkOutput("up_wrap", 32'(bus.wrap), 32'(i == 5));
    end

    // Scan down, dwell 0, from 1.
    applyStimulus(1'b1, 3, 1, 1'b1, 0);
    checkOutput("dn_load", 32'(bus.idx), 32'd1);
    exp_dn = '{0, 15, 14};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3, 0, 1'b0, 0);
      checkOutput("dn_seq", 32'(bus.idx), 32'(exp_dn[i]));
      checkOutput("dn_wrap", 32'(bus.wrap), 32'(i == 1));
    end

    // Load on the cycle a step is due.
    applyStimulus(1'b1, 2, 3, 1'b1, 2);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    applyStimulus(1'b1, 2, 9, 1'b1, 2);
    checkOutput("ld_scan_idx", 32'(bus.idx), 32'd9);
    checkOutput("ld_scan_wrap", 32'(bus.wrap), 32'd0);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    checkOutput("ld_scan_hold", 32'(bus.idx), 32'd9);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    checkOutput("ld_scan_step", 32'(bus.idx), 32'd10);

    // Freeze with en low, then resume with the counter intact.
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2, 4, 1'b1, 2);
      checkOutput("en0_y", 32'(bus.y), 32'h0);
      checkOutput("en0_idx", 32'(bus.idx), 32'd10);
    end
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    checkOutput("en1_y", 32'(bus.y), 32'h0400);
    applyStimulus(1'b1, 2, 0, 1'b0, 2);
    checkOutput("en1_step", 32'(bus.idx), 32'd11);

    applyStimulus(1'b1, 0, 0, 1'b0, 2);
    checkOutput("off_y", 32'(bus.y), 32'h0);
    checkOutput("off_idx", 32'(bus.idx), 32'd11);
    applyStimulus(1'b1, 0, 6, 1'b1, 2);
    checkOutput("off_load_y", 32'(bus.y), 32'h0);
    checkOutput("off_load_idx", 32'(bus.idx), 32'd6);

    // Randomized traffic against the model.
    begin
      int mode;
      int dwell;
      mode  = 2;
      dwell = 1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 9) == 0) mode = $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) dwell = $urandom_range(0, 3);
        applyStimulus($urandom_range(0, 7) != 0, mode, $urandom_range(0, OUT_W - 1),
                      $urandom_range(0, 7) == 0, dwell);
      end
    end

    // Asynchronous reset in the middle of a scan.
    applyStimulus(1'b1, 2, 7, 1'b1, 4);
    applyStimulus(1'b1, 2, 0, 1'b0, 4);
    checkOutput("pre_rst_y", 32'(bus.y), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_y", 32'(bus.y), 32'h0);
    checkOutput("arst_idx", 32'(bus.idx), 32'h0);
    checkOutput("arst_wrap", 32'(bus.wrap), 32'h0);
    checkOutput("arst_valid", 32'(bus.valid), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 3, $urandom_range(0, OUT_W - 1), $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
